regfile_store_seq: RTL and testbench
====================================

Name: regfile_store_seq

Overview:
- Read-side sequencer for store-multiple (STM-style) transfers in the 32-bit ARM-like core.
- Takes a 16-bit register list and a base address, then walks the list lowest register first.
- For each set bit it drives the register file's read-address port, captures the read data, and emits one (address, data) beat to the memory side over a valid/ready handshake.
- Sits between the control unit and the data-memory write path. It is the consumer of register contents that the writeback path produces.

Parameters:
- ADDR_STEP, 4, byte increment added to the beat address after each accepted beat.
- NREGS, 16, width of the register list (r0..r15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a transfer. Sampled only while busy=0.
- reglist  in  16  bit i set means register ri is stored. Sampled with start.
- base_addr  in  32  first beat address. Sampled with start.
- ra  out  4  register-file read address (combinational from internal state).
- rd  in  32  register-file read data for ra (asynchronous read; r15 is supplied by the register file).
- m_valid  out  1  beat valid.
- m_ready  in  1  memory side accepts the beat.
- m_addr  out  32  beat address.
- m_data  out  32  beat data.
- m_last  out  1  final beat of the transfer, qualified by m_valid.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: synchronous. State=IDLE; pending=0; m_valid, m_last, busy, done = 0; m_addr, m_data = 0; ra=0.
- States: IDLE, LOAD, ISSUE.
- IDLE:
  - start=1 and reglist!=0: pending<=reglist, cur_addr<=base_addr, go to LOAD.
  - start=1 and reglist==0: done<=1 for one cycle, stay IDLE, no beats.
  - start=0: hold.
- ra rule: ra = index of the lowest set bit of pending, or 0 if pending==0.
- LOAD (one cycle):
  - m_data<=rd, m_addr<=cur_addr, m_valid<=1, m_last<=(only one bit left in pending).
  - Clear that bit in pending; cur_addr<=cur_addr+ADDR_STEP; go to ISSUE.
- ISSUE:
  - m_valid=1, m_ready=0: hold m_addr, m_data, m_last stable.
  - Handshake (m_valid & m_ready) with pending!=0: perform the LOAD action in the same edge, giving back-to-back beats at 1 beat/cycle.
  - Handshake with m_last=1: m_valid<=0, m_last<=0, done<=1 for one cycle, go to IDLE.
- Latency: start sampled at edge E0, first m_valid after edge E1. With m_ready held high, N beats are accepted on edges E2..E(N+1), and done is high in the cycle after E(N+1).
- busy=1 exactly when state!=IDLE. busy=0 in the done cycle. start is ignored while busy=1.
- Address arithmetic is modulo 2^32: 0xFFFFFFFC+4 wraps to 0x00000000.
- Data is captured at each LOAD edge, not at start. The control unit must not write the register file during a transfer.
- Register 15 is read like any other; its value is whatever the register file presents on rd.
- reset during a transfer: all state cleared at that edge, m_valid drops immediately, no done pulse, remaining beats discarded.

Optional Feature:
- Macro: REGFILE_STORE_SEQ_WB_EN.
- When defined, three extra outputs are added:
  - base_we (1): pulses with done.
  - base_wd (32): base_addr + ADDR_STEP x popcount(reglist).
  - base_wa (4): driven from an extra input base_ra (4), sampled with start.
- Together these implement base-register writeback.
- An empty list still pulses base_we, with base_wd=base_addr.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- r1=0x12345678, r2=0x87654321, reglist=0x0006, base=0x1000, m_ready=1 -> beats (0x1000,0x12345678) then (0x1004,0x87654321,m_last=1) on consecutive cycles; done one cycle after the last beat; ra=1 then 2.
- Same transfer with m_ready low for 3 cycles on the first beat -> m_valid, m_addr, m_data held unchanged for 3 cycles, then both beats delivered; total exactly 2 beats.
- reglist=0x8001, r0=0xABCDEF00, r15=0xCAFEBABE, base=0xFFFFFFFC -> beats (0xFFFFFFFC,0xABCDEF00), (0x00000000,0xCAFEBABE,last).
- reglist=0x0000 with start -> done the next cycle, m_valid never asserted, busy stays 0.
- reglist=0xFFFF, reset asserted after the 5th beat -> m_valid=0 and busy=0 the next cycle, no done; a new start=1 with reglist=0x0002 then works normally.
- With REGFILE_STORE_SEQ_WB_EN, reglist=0x8003, base=0x2000, base_ra=13 -> base_we pulses together with done, base_wa=13, base_wd=0x200C.

Source files
------------

// File: rtl/regfile_store_seq_if.sv
// Beat channel from the store-multiple sequencer to the data-memory write path.
// The sequencer drives the master side; the memory write path is the slave.
interface regfile_store_seq_if;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        m_last;

    modport master (
        output m_valid,
        input  m_ready,
        output m_addr,
        output m_data,
        output m_last
    );

    modport slave (
        input  m_valid,
        output m_ready,
        input  m_addr,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/regfile_store_seq.sv
// STM-style read sequencer: walks a register list lowest-first and emits (address, data) beats.
// Optional base-register writeback outputs are enabled by defining REGFILE_STORE_SEQ_WB_EN.
module regfile_store_seq #(
    parameter int ADDR_STEP = 4,
    parameter int NREGS     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NREGS-1:0]         reglist,
    input  logic [31:0]              base_addr,
    output logic [$clog2(NREGS)-1:0] ra,
    input  logic [31:0]              rd,
    regfile_store_seq_if.master      m,
`ifdef REGFILE_STORE_SEQ_WB_EN
    input  logic [$clog2(NREGS)-1:0] base_ra,
    output logic                     base_we,
    output logic [31:0]              base_wd,
    output logic [$clog2(NREGS)-1:0] base_wa,
`endif
    output logic                     busy,
    output logic                     done
);

    localparam int IW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE
    } state_t;

    state_t             state_reg;
    logic [NREGS-1:0]   pending_reg;
    logic [31:0]        cur_addr_reg;
    logic               m_valid_reg;
    logic               m_last_reg;
    logic [31:0]        m_addr_reg;
    logic [31:0]        m_data_reg;
    logic               done_reg;

    logic [NREGS-1:0]   low_bit;
    logic [NREGS-1:0]   pending_next;
    logic               single_left;
    logic               handshake;
    logic               do_load;

    // Isolating the lowest set bit and clearing it share the same pending-1 term.
    assign low_bit      = pending_reg & (~pending_reg + NREGS'(1));
    assign pending_next = pending_reg & (pending_reg - NREGS'(1));
    assign single_left  = (pending_next == '0);
    assign handshake    = m_valid_reg & m.m_ready;
    assign do_load      = (state_reg == ST_LOAD) ||
                          ((state_reg == ST_ISSUE) && handshake && (pending_reg != '0));

    // One-hot to binary: each ra bit ORs the one-hot positions whose index has that bit set.
    generate
        for (genvar gi = 0; gi < IW; gi++) begin : g_enc
            logic [NREGS-1:0] sel;
            for (genvar gj = 0; gj < NREGS; gj++) begin : g_sel
                assign sel[gj] = 1'((gj >> gi) & 1);
            end
            assign ra[gi] = |(low_bit & sel);
        end
    endgenerate

`ifdef REGFILE_STORE_SEQ_WB_EN
    logic [CW-1:0] pop_cnt;
    logic [31:0]   base_wd_reg;
    logic [IW-1:0] base_wa_reg;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            pop_cnt = pop_cnt + CW'(reglist[i]);
        end
    end

    assign base_we = done_reg;
    assign base_wd = base_wd_reg;
    assign base_wa = base_wa_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            pending_reg  <= '0;
            cur_addr_reg <= '0;
            m_valid_reg  <= 1'b0;
            m_last_reg   <= 1'b0;
            m_addr_reg   <= '0;
            m_data_reg   <= '0;
            done_reg     <= 1'b0;
`ifdef REGFILE_STORE_SEQ_WB_EN
            base_wd_reg  <= '0;
            base_wa_reg  <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
`ifdef REGFILE_STORE_SEQ_WB_EN
                        base_wd_reg <= base_addr + 32'(ADDR_STEP) * 32'(pop_cnt);
                        base_wa_reg <= base_ra;
`endif
                        if (reglist != '0) begin
                            pending_reg  <= reglist;
                            cur_addr_reg <= base_addr;
                            state_reg    <= ST_LOAD;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                end
                ST_ISSUE: begin
                    if (handshake && m_last_reg) begin
                        m_valid_reg <= 1'b0;
                        m_last_reg  <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // Loading the next beat on the accepting edge keeps the stream at one beat per cycle.
            if (do_load) begin
                m_data_reg   <= rd;
                m_addr_reg   <= cur_addr_reg;
                m_valid_reg  <= 1'b1;
                m_last_reg   <= single_left;
                pending_reg  <= pending_next;
                cur_addr_reg <= cur_addr_reg + 32'(ADDR_STEP);
                state_reg    <= ST_ISSUE;
            end
        end
    end

    assign m.m_valid = m_valid_reg;
    assign m.m_last  = m_last_reg;
    assign m.m_addr  = m_addr_reg;
    assign m.m_data  = m_data_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;

endmodule

// File: tb/tb_regfile_store_seq.sv
// Directed bench for regfile_store_seq: one task per scenario, inline checks, one summary line.
module tb_regfile_store_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] reglist;
    logic [31:0] base_addr;
    logic [3:0]  ra;
    logic [31:0] rd;
    logic        busy;
    logic        done;
    logic [31:0] regs [16];
`ifdef REGFILE_STORE_SEQ_WB_EN
    logic [3:0]  base_ra;
    logic        base_we;
    logic [31:0] base_wd;
    logic [3:0]  base_wa;
`endif

    int total = 0;
    int bad   = 0;

    regfile_store_seq_if mif();

    regfile_store_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .reglist   (reglist),
        .base_addr (base_addr),
        .ra        (ra),
        .rd        (rd),
        .m         (mif.master),
`ifdef REGFILE_STORE_SEQ_WB_EN
        .base_ra   (base_ra),
        .base_we   (base_we),
        .base_wd   (base_wd),
        .base_wa   (base_wa),
`endif
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    assign rd = regs[ra];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; reglist = '0; base_addr = '0; mif.m_ready = 1'b0;
`ifdef REGFILE_STORE_SEQ_WB_EN
        base_ra = '0;
`endif
        for (int i = 0; i < 16; i++) regs[i] = 32'h0;
        tick(); tick();
        reset = 1'b0;
        total++; if (mif.m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", mif.m_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (mif.m_addr !== 32'h0 || mif.m_data !== 32'h0) begin bad++; $display("FAIL reset_addr_data: got %h/%h want 0/0", mif.m_addr, mif.m_data); end
        total++; if (ra !== 4'd0 || mif.m_last !== 1'b0) begin bad++; $display("FAIL reset_ra_last: got %0d/%b want 0/0", ra, mif.m_last); end
        tick();
    endtask

    task automatic test_basic;
        regs[1] = 32'h12345678; regs[2] = 32'h87654321;
        start = 1'b1; reglist = 16'h0006; base_addr = 32'h1000; mif.m_ready = 1'b1;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1 || mif.m_valid !== 1'b0) begin bad++; $display("FAIL basic_load: busy/valid got %b/%b want 1/0", busy, mif.m_valid); end
        total++; if (ra !== 4'd1) begin bad++; $display("FAIL basic_ra1: got %0d want 1", ra); end
        tick();
        total++; if (mif.m_valid !== 1'b1 || mif.m_addr !== 32'h1000 || mif.m_data !== 32'h12345678 || mif.m_last !== 1'b0)
            begin bad++; $display("FAIL basic_beat0: got v=%b a=%h d=%h l=%b want 1/1000/12345678/0", mif.m_valid, mif.m_addr, mif.m_data, mif.m_last); end
        total++; if (ra !== 4'd2) begin bad++; $display("FAIL basic_ra2: got %0d want 2", ra); end
        tick();
        total++; if (mif.m_valid !== 1'b1 || mif.m_addr !== 32'h1004 || mif.m_data !== 32'h87654321 || mif.m_last !== 1'b1)
            begin bad++; $display("FAIL basic_beat1: got v=%b a=%h d=%h l=%b want 1/1004/87654321/1", mif.m_valid, mif.m_addr, mif.m_data, mif.m_last); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_early_done: got %b want 0", done); end
        tick();
        total++; if (done !== 1'b1 || busy !== 1'b0 || mif.m_valid !== 1'b0)
            begin bad++; $display("FAIL basic_done: got done=%b busy=%b valid=%b want 1/0/0", done, busy, mif.m_valid); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_stall;
        start = 1'b1; reglist = 16'h0006; base_addr = 32'h1000; mif.m_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (mif.m_valid !== 1'b1 || mif.m_addr !== 32'h1000 || mif.m_data !== 32'h12345678 || mif.m_last !== 1'b0)
                begin bad++; $display("FAIL stall_hold%0d: got v=%b a=%h d=%h l=%b want 1/1000/12345678/0", k, mif.m_valid, mif.m_addr, mif.m_data, mif.m_last); end
            // A start pulse while busy must be ignored.
            if (k == 1) begin start = 1'b1; reglist = 16'h00F0; end
            if (k == 2) begin start = 1'b0; reglist = 16'h0000; mif.m_ready = 1'b1; end
        end
        tick();
        total++; if (mif.m_valid !== 1'b1 || mif.m_addr !== 32'h1004 || mif.m_data !== 32'h87654321 || mif.m_last !== 1'b1)
            begin bad++; $display("FAIL stall_beat1: got v=%b a=%h d=%h l=%b want 1/1004/87654321/1", mif.m_valid, mif.m_addr, mif.m_data, mif.m_last); end
        tick();
        total++; if (done !== 1'b1 || mif.m_valid !== 1'b0) begin bad++; $display("FAIL stall_done: got done=%b valid=%b want 1/0", done, mif.m_valid); end
        tick();
        total++; if (busy !== 1'b0 || mif.m_valid !== 1'b0) begin bad++; $display("FAIL stall_extra: got busy=%b valid=%b want 0/0", busy, mif.m_valid); end
    endtask

    task automatic test_wrap;
        regs[0] = 32'hABCDEF00; regs[15] = 32'hCAFEBABE;
        start = 1'b1; reglist = 16'h8001; base_addr = 32'hFFFFFFFC; mif.m_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++; if (mif.m_valid !== 1'b1 || mif.m_addr !== 32'hFFFFFFFC || mif.m_data !== 32'hABCDEF00 || mif.m_last !== 1'b0)
            begin bad++; $display("FAIL wrap_beat0: got v=%b a=%h d=%h l=%b want 1/fffffffc/abcdef00/0", mif.m_valid, mif.m_addr, mif.m_data, mif.m_last); end
        total++; if (ra !== 4'd15) begin bad++; $display("FAIL wrap_ra15: got %0d want 15", ra); end
        tick();
        total++; if (mif.m_valid !== 1'b1 || mif.m_addr !== 32'h00000000 || mif.m_data !== 32'hCAFEBABE || mif.m_last !== 1'b1)
            begin bad++; $display("FAIL wrap_beat1: got v=%b a=%h d=%h l=%b want 1/00000000/cafebabe/1", mif.m_valid, mif.m_addr, mif.m_data, mif.m_last); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL wrap_done: got %b want 1", done); end
    endtask

    task automatic test_empty;
        start = 1'b1; reglist = 16'h0000; base_addr = 32'h5000; mif.m_ready = 1'b1;
        tick();
        start = 1'b0;
        total++; if (done !== 1'b1 || busy !== 1'b0 || mif.m_valid !== 1'b0)
            begin bad++; $display("FAIL empty_done: got done=%b busy=%b valid=%b want 1/0/0", done, busy, mif.m_valid); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0 || mif.m_valid !== 1'b0)
            begin bad++; $display("FAIL empty_after: got done=%b busy=%b valid=%b want 0/0/0", done, busy, mif.m_valid); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 16; i++) regs[i] = 32'h10000000 + 32'(i);
        start = 1'b1; reglist = 16'hFFFF; base_addr = 32'h3000; mif.m_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++; if (mif.m_valid !== 1'b1 || mif.m_addr !== 32'h3000 + 32'(4 * (k - 1)) || mif.m_data !== 32'h10000000 + 32'(k - 1))
                begin bad++; $display("FAIL rmid_beat%0d: got v=%b a=%h d=%h want 1/%h/%h", k, mif.m_valid, mif.m_addr, mif.m_data, 32'h3000 + 32'(4 * (k - 1)), 32'h10000000 + 32'(k - 1)); end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (mif.m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL rmid_cleared: got valid=%b busy=%b done=%b want 0/0/0", mif.m_valid, busy, done); end
        tick();
        total++; if (mif.m_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rmid_quiet: got valid=%b done=%b want 0/0", mif.m_valid, done); end
        start = 1'b1; reglist = 16'h0002; base_addr = 32'h4000;
        tick();
        start = 1'b0;
        tick();
        total++; if (mif.m_valid !== 1'b1 || mif.m_addr !== 32'h4000 || mif.m_data !== 32'h10000001 || mif.m_last !== 1'b1)
            begin bad++; $display("FAIL rmid_restart: got v=%b a=%h d=%h l=%b want 1/4000/10000001/1", mif.m_valid, mif.m_addr, mif.m_data, mif.m_last); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rmid_restart_done: got %b want 1", done); end
    endtask

`ifdef REGFILE_STORE_SEQ_WB_EN
    task automatic test_writeback;
        start = 1'b1; reglist = 16'h8003; base_addr = 32'h2000; base_ra = 4'd13; mif.m_ready = 1'b1;
        tick();
        start = 1'b0; base_ra = 4'd0;
        tick(); tick(); tick();
        total++; if (base_we !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL wb_early: got we=%b done=%b want 0/0", base_we, done); end
        tick();
        total++; if (base_we !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL wb_pulse: got we=%b done=%b want 1/1", base_we, done); end
        total++; if (base_wa !== 4'd13 || base_wd !== 32'h200C) begin bad++; $display("FAIL wb_data: got wa=%0d wd=%h want 13/200c", base_wa, base_wd); end
        tick();
        total++; if (base_we !== 1'b0) begin bad++; $display("FAIL wb_pulse_end: got %b want 0", base_we); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_empty();
        test_reset_mid();
`ifdef REGFILE_STORE_SEQ_WB_EN
        test_writeback();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
